// File: rtl/divider.sv
// Sequential signed 32-bit restoring divider sharing the multiplier's start/ready handshake.
// Optional DIV_REMAINDER_EN adds the data_remainder port and its sign-fix logic.
module divider (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [31:0] data_remainder
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Magnitude of a two's-complement word; INT_MIN maps to unsigned 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    neg_if = en ? (~v + 32'd1) : v;
  endfunction

  logic [1:0]  state_r;
  logic [5:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quot_r;
  logic [31:0] divisor_r;
  logic        neg_q_r;
  logic        div_zero_r;

  logic [32:0] shift_rem_s;
  logic [32:0] trial_s;
  logic [31:0] next_rem_s;
  logic [31:0] next_quot_s;
  logic        finish_s;

  // One restoring shift-subtract step on the working register.
  always_comb begin
    shift_rem_s = {rem_r, quot_r[31]};
    trial_s     = shift_rem_s - {1'b0, divisor_r};
    next_rem_s  = shift_rem_s[31:0];
    next_quot_s = {quot_r[30:0], 1'b0};
    if (!trial_s[32]) begin
      next_rem_s  = trial_s[31:0];
      next_quot_s = {quot_r[30:0], 1'b1};
    end else begin
      next_rem_s  = shift_rem_s[31:0];
      next_quot_s = {quot_r[30:0], 1'b0};
    end
  end

  // A new start takes priority over completing the current division.
  always_comb begin
    finish_s = 1'b0;
    if ((state_r == ST_RUN) && !ctrl_DIV) begin
      finish_s = div_zero_r || (cnt_r == 6'd32);
    end else begin
      finish_s = 1'b0;
    end
  end

  // Control FSM and iteration datapath; count value 32 marks the completion cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 6'd0;
      rem_r      <= 32'd0;
      quot_r     <= 32'd0;
      divisor_r  <= 32'd0;
      neg_q_r    <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (ctrl_DIV) begin
      state_r    <= ST_RUN;
      cnt_r      <= 6'd0;
      rem_r      <= 32'd0;
      quot_r     <= abs32(data_operandA);
      divisor_r  <= abs32(data_operandB);
      neg_q_r    <= data_operandA[31] ^ data_operandB[31];
      div_zero_r <= (data_operandB == 32'd0);
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_RUN: begin
          if (finish_s) begin
            state_r <= ST_DONE;
          end else begin
            rem_r  <= next_rem_s;
            quot_r <= next_quot_s;
            cnt_r  <= cnt_r + 6'd1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Result registers load only on entry to DONE and otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish_s;
      if (finish_s) begin
        data_result    <= div_zero_r ? 32'd0 : neg_if(quot_r, neg_q_r);
        data_exception <= div_zero_r;
      end else begin
        data_result    <= data_result;
        data_exception <= data_exception;
      end
    end
  end

`ifdef DIV_REMAINDER_EN
  logic neg_a_r;

  // Remainder takes the dividend's sign; zero on divide-by-zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      neg_a_r        <= 1'b0;
      data_remainder <= 32'd0;
    end else begin
      if (ctrl_DIV) begin
        neg_a_r <= data_operandA[31];
      end else begin
        neg_a_r <= neg_a_r;
      end
      if (finish_s) begin
        data_remainder <= div_zero_r ? 32'd0 : neg_if(rem_r, neg_a_r);
      end else begin
        data_remainder <= data_remainder;
      end
    end
  end
`endif

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: latency, signs, divide-by-zero, restart, reset.
module tb_divider;

  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks_r;
  int errors_r;

  divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a start so that the next rising edge is E0; operands are scrambled afterwards.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0000_0000;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic exc, input int lat_exp);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) lat = k;
    end
    check_val({tag, "_lat"}, lat, lat_exp);
    check_val({tag, "_q"}, data_result, q);
    check_val({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exc});
`ifdef DIV_REMAINDER_EN
    check_val({tag, "_rem"}, data_remainder, r);
`else
    if (r !== r) $display("unreachable");
`endif
    @(posedge clock);
    #1;
    check_val({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic exc,
                         input int lat_exp);
    start_div(a, b);
    wait_done(tag, q, r, exc, lat_exp);
  endtask

  initial begin
    int rdy_seen;
    checks_r      = 0;
    errors_r      = 0;
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_q", data_result, 32'd0);
    check_val("reset_exc", {31'd0, data_exception}, 32'd0);
    check_val("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_div("p100_p7",   32'd100,          32'd7,          32'd14,          32'd2,          1'b0, 33);
    run_div("n100_p7",   -32'sd100,        32'd7,          -32'sd14,        -32'sd2,        1'b0, 33);
    run_div("p100_n7",   32'd100,          -32'sd7,        -32'sd14,        32'd2,          1'b0, 33);
    run_div("n100_n7",   -32'sd100,        -32'sd7,        32'd14,          -32'sd2,        1'b0, 33);
    run_div("p7_n2",     32'd7,            -32'sd2,        -32'sd3,         32'd1,          1'b0, 33);
    run_div("div0",      32'd5,            32'd0,          32'd0,           32'd0,          1'b1, 1);
    run_div("p9_p3",     32'd9,            32'd3,          32'd3,           32'd0,          1'b0, 33);
    run_div("min_n1",    32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,   32'd0,          1'b0, 33);
    run_div("max_p1",    32'h7FFF_FFFF,    32'd1,          32'h7FFF_FFFF,   32'd0,          1'b0, 33);
    run_div("p3_p10",    32'd3,            32'd10,         32'd0,           32'd3,          1'b0, 33);

    // Abort 1000/10 at E10 with 81/9: single RDY 33 cycles after the restart.
    start_div(32'd1000, 32'd10);
    repeat (9) @(posedge clock);
    #1;
    start_div(32'd81, 32'd9);
    wait_done("restart", 32'd9, 32'd0, 1'b0, 33);

    // Outputs hold across a new start, then reset at E20 wipes everything.
    start_div(32'd100, 32'd7);
    repeat (5) @(posedge clock);
    #1;
    check_val("hold_q", data_result, 32'd9);
    repeat (14) @(posedge clock);
    #1;
    reset_n  = 1'b0;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    check_val("rst_mid_q", data_result, 32'd0);
    check_val("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset_n  = 1'b1;
    ctrl_DIV = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    check_val("rst_no_rdy", rdy_seen, 32'd0);
    check_val("rst_after_q", data_result, 32'd0);
    check_val("rst_after_exc", {31'd0, data_exception}, 32'd0);

    run_div("post_rst", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
